hamming_decoder: RTL and testbench

Receive-side Hamming(16,11) SECDED decoder, the counterpart of the program-level encoder that packs 11 data bits plus 5 parity bits into a 16-bit word. Accepts codewords one byte at a time over a valid/ready stream, checks the syndrome and overall parity, corrects single-bit errors and flags double-bit errors. Emits one status-tagged 16-bit result per codeword with backpressure, and keeps saturating error counters for the datapath and testbench.

---
 rtl/hamming_decoder.sv | 129 ++++++++++++
 tb/tb_hamming_decoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// hamming_decoder
//   Receive-side Hamming(16,11) SECDED decoder. Collects a codeword as two
//   bytes (low byte first), checks syndrome and overall parity, corrects a
//   single-bit error, flags a double-bit error and hands out one
//   status-tagged result per codeword over a valid/ready stream.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    in_byte is valid
//   in_ready    decoder accepts a byte this cycle (state LO/HI)
//   in_byte     codeword byte, b7..b0 first then b15..b8
//   out_valid   out_word holds a decoded result (state OUT)
//   out_ready   consumer takes out_word this cycle
//   out_word    {status[1:0], 3'b000, d11..d1}
//   clear_cnt   synchronous clear of both error counters
//   cnt_single  saturating count of status-01 codewords
//   cnt_double  saturating count of status-10 codewords
//
// state | meaning
// LO    | waiting for low byte (b7..b0)
// HI    | waiting for high byte (b15..b8)
// DEC   | decode latched codeword, load out_word, bump counters
// OUT   | result presented, held until out_ready
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_word,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  typedef enum logic [1:0] {LO, HI, DEC, OUT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [7:0]  lo_byte;
  logic [7:0]  hi_byte;

  logic [15:0] cw;
  logic [15:0] fixed;
  logic [3:0]  syn;
  logic        par;
  logic [1:0]  status;
  logic [10:0] data;

  // Handshake flags come straight from the state register, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (state == LO) || (state == HI);
  assign out_valid = (state == OUT);

  always_comb begin
    cw     = {hi_byte, lo_byte};
    syn    = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) syn = syn ^ 4'(i);
    end
    par    = ^cw;
    fixed  = cw;
    status = 2'b00;
    if (syn != 4'd0 && par) begin
      fixed[syn] = ~cw[syn];
      status     = 2'b01;
    end else if (syn == 4'd0 && par) begin
      // only p0 is wrong; data bits are untouched
      status = 2'b01;
    end else if (syn != 4'd0 && !par) begin
      // double error: data passed through uncorrected
      status = 2'b10;
    end
    data = {fixed[15:9], fixed[7:5], fixed[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LO;
      lo_byte  <= 8'h00;
      hi_byte  <= 8'h00;
      out_word <= 16'h0000;
    end else begin
      case (state)
        LO: begin
          if (in_valid) begin
            lo_byte <= in_byte;
            state   <= HI;
          end
        end
        HI: begin
          if (in_valid) begin
            hi_byte <= in_byte;
            state   <= DEC;
          end
        end
        DEC: begin
          out_word <= {status, 3'b000, data};
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) state <= LO;
        end
        default: state <= LO;
      endcase
    end
  end

  // Clear takes priority over an increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (clear_cnt) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (state == DEC) begin
      if (status == 2'b01 && cnt_single != CNT_MAX) cnt_single <= cnt_single + 1'b1;
      if (status == 2'b10 && cnt_double != CNT_MAX) cnt_double <= cnt_double + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
module tb_hamming_decoder;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_byte = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_word;
  logic             clear_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;

  int n_checks = 0;
  int n_pass   = 0;

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .clear_cnt  (clear_cnt),
    .cnt_single (cnt_single),
    .cnt_double (cnt_double)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present a byte at the falling edge and hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Full codeword with out_ready high; optionally pulse clear_cnt in DEC.
  task automatic codeword(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [15:0] exp_word, input int exp_s, input int exp_d,
                          input bit clr_in_dec);
    send_byte(lo);
    send_byte(hi);
    chk({tag, "_ov_dec"}, {15'd0, out_valid}, 16'd0);
    if (clr_in_dec) clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
    chk({tag, "_ov"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_word"}, out_word, exp_word);
    chk({tag, "_cs"}, {14'd0, cnt_single}, 16'(exp_s));
    chk({tag, "_cd"}, {14'd0, cnt_double}, 16'(exp_d));
    @(posedge clk);
    #1;
    chk({tag, "_done"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_word", out_word, 16'h0000);
    chk("rst_cnt", {12'd0, cnt_single, cnt_double}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // clean codeword, single data error, p0-only error, double error
    codeword("clean",  8'h0F, 8'h00, 16'h0001, 0, 0, 1'b0);
    codeword("single", 8'h20, 8'h00, 16'h4000, 1, 0, 1'b0);
    codeword("p0",     8'h01, 8'h00, 16'h4000, 2, 0, 1'b0);
    codeword("double", 8'h03, 8'h00, 16'h8000, 2, 1, 1'b0);

    // backpressure on a clean codeword carrying d5
    out_ready = 1'b0;
    send_byte(8'h03);
    send_byte(8'h03);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_byte  = 8'hAA;
      chk("bp_ov", {15'd0, out_valid}, 16'd1);
      chk("bp_word", out_word, 16'h0010);
      chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ov", {15'd0, out_valid}, 16'd0);
    chk("bp_release_ir", {15'd0, in_ready}, 16'd1);
    chk("bp_word_kept", out_word, 16'h0010);
    chk("bp_cnt", {12'd0, cnt_single, cnt_double}, 16'h0009);

    // the 0xAA offered during OUT must not have been taken
    codeword("after_bp", 8'h0F, 8'h00, 16'h0001, 2, 1, 1'b0);
    // error in b15 of the d5 codeword
    codeword("hi_err",   8'h03, 8'h83, 16'h4010, 3, 1, 1'b0);

    // clear, then saturate cnt_single
    @(negedge clk);
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    chk("clear_cnt", {12'd0, cnt_single, cnt_double}, 16'h0000);
    codeword("sat1", 8'h20, 8'h00, 16'h4000, 1, 0, 1'b0);
    codeword("sat2", 8'h20, 8'h00, 16'h4000, 2, 0, 1'b0);
    codeword("sat3", 8'h20, 8'h00, 16'h4000, 3, 0, 1'b0);
    codeword("sat4", 8'h20, 8'h00, 16'h4000, 3, 0, 1'b0);
    codeword("clr_dec", 8'h20, 8'h00, 16'h4000, 0, 0, 1'b1);
    codeword("dbl2", 8'h03, 8'h00, 16'h8000, 0, 1, 1'b0);

    // async reset after only the low byte
    send_byte(8'h0F);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("arst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("arst_word", out_word, 16'h0000);
    chk("arst_cnt", {12'd0, cnt_single, cnt_double}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    codeword("post_rst", 8'h0F, 8'h00, 16'h0001, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
